// File: rtl/kmap_mux_engine.sv
// kmap_mux_engine: K-map/mux evaluator with shadow/active truth-table banks and a 2-stage valid/ready pipeline
// Define KMAP_EVAL_CNT_EN to add the saturating completion counter output eval_cnt.
module kmap_mux_engine #(
    parameter int SEL_W = 2,
    parameter int RES_W = 2,
    localparam int N_IN = 2**SEL_W,
    localparam int TT_W = 2**RES_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_idx,
    input  logic [TT_W-1:0]  cfg_tt,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [RES_W-1:0] in_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_mux_in,
    output logic             out_f
`ifdef KMAP_EVAL_CNT_EN
    ,
    output logic [15:0]      eval_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
    state_t                      state_q;
    logic [N_IN-1:0][TT_W-1:0]   shadow_q, active_q;
    logic                        s1_v_q, out_valid_q, out_f_q;
    logic [N_IN-1:0]             s1_mux_q, out_mux_q, mux_d;
    logic [SEL_W-1:0]            s1_sel_q;
    logic                        s2_free, s1_free, accept, drain_done;
    for (genvar i = 0; i < N_IN; i++) begin : g_mux
        assign mux_d[i] = active_q[i][in_res];
    end
    assign s2_free    = ~out_valid_q | out_ready;
    assign s1_free    = ~s1_v_q | s2_free;
    assign in_ready   = (state_q == RUN) & s1_free;
    assign accept     = in_valid & in_ready;
    assign drain_done = (state_q == DRAIN) & ~s1_v_q & ~out_valid_q;
    assign cfg_busy   = state_q != RUN;
    assign out_valid  = out_valid_q;
    assign out_mux_in = out_mux_q;
    assign out_f      = out_f_q;
`ifdef KMAP_EVAL_CNT_EN
    logic [15:0] eval_cnt_q;
    assign eval_cnt = eval_cnt_q;
    always_ff @(posedge clk) begin
        if (reset || drain_done)
            eval_cnt_q <= '0;
        else if (out_valid_q && out_ready && eval_cnt_q != 16'hFFFF)
            eval_cnt_q <= eval_cnt_q + 16'd1;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            active_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_mux_q    <= '0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_mux_q   <= '0;
            out_f_q     <= 1'b0;
        end else begin
            if (cfg_we)
                shadow_q[cfg_idx] <= cfg_tt;
            case (state_q)
                RUN:     state_q <= cfg_commit ? DRAIN : RUN;
                DRAIN:   state_q <= drain_done ? SWAP : DRAIN;
                SWAP: begin
                    active_q <= shadow_q;
                    state_q  <= RUN;
                end
                default: state_q <= RUN;
            endcase
            // S1 captures the evaluated vector, so later table swaps never touch in-flight work
            if (s1_free) begin
                s1_v_q <= accept;
                if (accept) begin
                    s1_mux_q <= mux_d;
                    s1_sel_q <= in_sel;
                end
            end
            if (s2_free) begin
                out_valid_q <= s1_v_q;
                if (s1_v_q) begin
                    out_mux_q <= s1_mux_q;
                    out_f_q   <= s1_mux_q[s1_sel_q];
                end
            end
        end
    end
endmodule
